// File: rtl/phase_timer_if.sv
// Phase timer bus: the controller phase and sensor inputs going into the
// timer, plus the countdown status coming back out.
//   state           : controller phase code (0..7)
//   sig_Full        : tank full sensor
//   sig_Temperature : target temperature reached
//   sig_Hold        : pause request, freezes the countdown
//   sig_Completed   : one-cycle pulse when the current phase finishes
//   sig_Time_Out    : level, FILL/HEAT watchdog expired
//   remaining       : current countdown value
//   busy            : timer is counting
// master drives the phase/sensors (controller side), slave is the timer.
interface phase_timer_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       state;
    logic             sig_Full;
    logic             sig_Temperature;
    logic             sig_Hold;
    logic             sig_Completed;
    logic             sig_Time_Out;
    logic [WIDTH-1:0] remaining;
    logic             busy;

    modport master (
        output state, sig_Full, sig_Temperature, sig_Hold,
        input  sig_Completed, sig_Time_Out, remaining, busy
    );

    modport slave (
        input  state, sig_Full, sig_Temperature, sig_Hold,
        output sig_Completed, sig_Time_Out, remaining, busy
    );
endinterface

// File: rtl/phase_timer.sv
// Per-phase countdown / watchdog for a washing-machine controller.
// A change of the controller phase reloads the timer with that phase's
// limit. FILL and HEAT are watchdogged: their sensor finishes the phase,
// running out of time raises sig_Time_Out. WASH, RINSE and SPIN simply
// complete when the count reaches zero. sig_Hold pauses the count.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : phase_timer_if.slave (phase/sensors in, status out)
module phase_timer #(
    parameter int          WIDTH   = 16,
    parameter int unsigned T_FILL  = 1000,
    parameter int unsigned T_HEAT  = 2000,
    parameter int unsigned T_WASH  = 3000,
    parameter int unsigned T_RINSE = 2000,
    parameter int unsigned T_SPIN  = 1500
) (
    input  logic          clock,
    input  logic          reset,
    phase_timer_if.slave  bus
);
    localparam logic [2:0] PH_FILL  = 3'd2;
    localparam logic [2:0] PH_HEAT  = 3'd3;
    localparam logic [2:0] PH_WASH  = 3'd4;
    localparam logic [2:0] PH_RINSE = 3'd5;
    localparam logic [2:0] PH_SPIN  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE, EXPIRED} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [2:0]       last_state_q;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             cmp_q, cmp_d;
    logic             phase_start;
    logic             timed_phase;
    logic             sensor_hit;

    // Limits are truncated to WIDTH on purpose.
    function automatic logic [WIDTH-1:0] phase_limit(input logic [2:0] ph);
        case (ph)
            PH_FILL:  phase_limit = WIDTH'(T_FILL);
            PH_HEAT:  phase_limit = WIDTH'(T_HEAT);
            PH_WASH:  phase_limit = WIDTH'(T_WASH);
            PH_RINSE: phase_limit = WIDTH'(T_RINSE);
            PH_SPIN:  phase_limit = WIDTH'(T_SPIN);
            default:  phase_limit = '0;
        endcase
    endfunction

    assign phase_start = (bus.state != last_state_q);
    assign timed_phase = (bus.state >= PH_FILL) && (bus.state <= PH_SPIN);
    // Sensors only matter in their own watchdogged phase.
    assign sensor_hit  = ((bus.state == PH_FILL) && bus.sig_Full) ||
                         ((bus.state == PH_HEAT) && bus.sig_Temperature);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q        <= IDLE;
            last_state_q <= 3'd0;
            rem_q        <= '0;
            cmp_q        <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            last_state_q <= bus.state;
            rem_q        <= rem_d;
            cmp_q        <= cmp_d;
        end
    end

    // Next-state logic. A phase change beats everything, including the
    // absorbing DONE/EXPIRED states and an in-flight countdown.
    always_comb begin
        fsm_d = fsm_q;
        rem_d = rem_q;
        cmp_d = 1'b0;
        if (phase_start) begin
            if (timed_phase) begin
                fsm_d = RUN;
                rem_d = phase_limit(bus.state);
            end else begin
                fsm_d = IDLE;
                rem_d = '0;
            end
        end else if (fsm_q == RUN) begin
            if (sensor_hit) begin
                // Completion wins over hold and over a coincident zero.
                fsm_d = DONE;
                cmp_d = 1'b1;
            end else if (!bus.sig_Hold) begin
                if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end else if ((bus.state == PH_FILL) || (bus.state == PH_HEAT)) begin
                    fsm_d = EXPIRED;
                end else begin
                    fsm_d = DONE;
                    cmp_d = 1'b1;
                end
            end
        end
    end

    // Outputs: all derived from registers. The timeout level is exactly
    // the EXPIRED state, which only a phase change or reset leaves.
    always_comb begin
        bus.busy          = (fsm_q == RUN);
        bus.sig_Time_Out  = (fsm_q == EXPIRED);
        bus.sig_Completed = cmp_q;
        bus.remaining     = rem_q;
    end
endmodule
